// File: rtl/prg_pkg.sv
// Shared encodings for the pseudo-random stream generator: mode, FSM states, common tap masks.
package prg_pkg;

  localparam logic MODE_FIB = 1'b0;
  localparam logic MODE_GAL = 1'b1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } prg_state_e;

  localparam logic [7:0]  DEFAULT_POLY_8  = 8'hB8;
  localparam logic [15:0] DEFAULT_POLY_16 = 16'hE801;
  localparam logic [31:0] DEFAULT_POLY_32 = 32'h8020_0003;

endpackage

// File: rtl/prg_lfsr_step.sv
// One combinational LFSR shift in either Fibonacci or Galois form.
module prg_lfsr_step
  import prg_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] poly,
  input  logic             mode,
  output logic [WIDTH-1:0] s_next
);

  always_comb begin
    s_next = '0;
    if (mode == MODE_GAL) begin
      s_next = (s >> 1) ^ (s[0] ? poly : '0);
    end else begin
      s_next = {^(s & poly), s[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/prg_lfsr_stream.sv
// LFSR word source on a valid/ready stream with runtime seed/poly/mode loading
// and zero-state lock-up recovery.
module prg_lfsr_stream
  import prg_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] DEFAULT_POLY = 16'hE801,
  parameter int               STEPS        = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             seed_valid,
  output logic             seed_ready,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] poly,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rand_data,
  output logic             lockup
);

  localparam logic [0:0]       ST_IDLE = IDLE;
  localparam logic [0:0]       ST_RUN  = RUN;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [0:0]       state;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] poly_r;
  logic             mode_r;
  logic [WIDTH-1:0] chain [0:STEPS];
  logic [WIDTH-1:0] adv;
  logic             load;
  logic             hs;

  // STEPS shifts unrolled in series; chain[STEPS] is the next word
  assign chain[0] = lfsr;
  for (genvar g = 0; g < STEPS; g++) begin : g_step
    prg_lfsr_step #(.WIDTH(WIDTH)) u_step (
      .s      (chain[g]),
      .poly   (poly_r),
      .mode   (mode_r),
      .s_next (chain[g+1])
    );
  end
  assign adv = chain[STEPS];

  assign out_valid  = (state == ST_RUN);
  assign rand_data  = lfsr;
  assign seed_ready = (state == ST_IDLE) || out_ready;
  assign load       = seed_valid && seed_ready;
  assign hs         = out_valid && out_ready;

  // A load takes priority over the advance; the seed becomes the next word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      lfsr   <= ONE;
      poly_r <= DEFAULT_POLY;
      mode_r <= MODE_FIB;
      lockup <= 1'b0;
    end else if (load) begin
      lfsr   <= (seed == '0) ? ONE : seed;
      poly_r <= (poly == '0) ? DEFAULT_POLY : poly;
      mode_r <= mode;
      lockup <= 1'b0;
      state  <= ST_RUN;
    end else if (hs) begin
      if (adv == '0) begin
        lfsr   <= ONE;
        lockup <= 1'b1;
      end else begin
        lfsr <= adv;
      end
      state <= enable ? ST_RUN : ST_IDLE;
    end else if (state == ST_IDLE && enable) begin
      state <= ST_RUN;
    end
  end

endmodule

// File: tb/tb_prg_lfsr_stream.sv
// Bench for prg_lfsr_stream: one STEPS=1 and one STEPS=2 instance on shared inputs,
// checked against a word-level reference model every cycle plus directed vectors.
module tb_prg_lfsr_stream;

  localparam int W = 16;
  localparam logic [W-1:0] DEF_POLY = 16'hE801;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         seed_valid;
  logic [W-1:0] seed;
  logic [W-1:0] poly;
  logic         mode;
  logic         out_ready;

  logic         seed_ready1, out_valid1, lockup1;
  logic [W-1:0] rand1;
  logic         seed_ready2, out_valid2, lockup2;
  logic [W-1:0] rand2;

  prg_lfsr_stream #(.WIDTH(W), .DEFAULT_POLY(DEF_POLY), .STEPS(1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .seed_valid(seed_valid),
    .seed_ready(seed_ready1), .seed(seed), .poly(poly), .mode(mode),
    .out_valid(out_valid1), .out_ready(out_ready), .rand_data(rand1),
    .lockup(lockup1)
  );

  prg_lfsr_stream #(.WIDTH(W), .DEFAULT_POLY(DEF_POLY), .STEPS(2)) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .seed_valid(seed_valid),
    .seed_ready(seed_ready2), .seed(seed), .poly(poly), .mode(mode),
    .out_valid(out_valid2), .out_ready(out_ready), .rand_data(rand2),
    .lockup(lockup2)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] m_s1, m_s2, m_poly;
  logic         m_mode, m_lk1, m_lk2, m_vld;

  // Word-level reference: n shifts computed with plain arithmetic
  function automatic logic [W-1:0] ref_adv(input logic [W-1:0] s, input logic [W-1:0] p,
                                           input logic md, input int n);
    logic [W-1:0] v;
    v = s;
    for (int i = 0; i < n; i++) begin
      if (md) v = (v % 2 == 1) ? ((v >> 1) ^ p) : (v >> 1);
      else    v = (v >> 1) | (W'($countones(v & p) % 2) << (W - 1));
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1; m_s2 = 1; m_poly = DEF_POLY; m_mode = 1'b0;
    m_lk1 = 1'b0; m_lk2 = 1'b0; m_vld = 1'b0;
  endtask

  task automatic check_all();
    chk("out_valid1", 64'(out_valid1), 64'(m_vld));
    chk("out_valid2", 64'(out_valid2), 64'(m_vld));
    chk("rand1", 64'(rand1), 64'(m_s1));
    chk("rand2", 64'(rand2), 64'(m_s2));
    chk("lockup1", 64'(lockup1), 64'(m_lk1));
    chk("lockup2", 64'(lockup2), 64'(m_lk2));
    chk("seed_ready1", 64'(seed_ready1), 64'(!m_vld || out_ready));
  endtask

  task automatic tick();
    logic ld, hs, en;
    logic [W-1:0] n, sd, pl;
    logic md;
    ld = seed_valid && (!m_vld || out_ready);
    hs = m_vld && out_ready;
    en = enable; sd = seed; pl = poly; md = mode;
    @(posedge clk);
    if (ld) begin
      m_s1 = (sd == 0) ? 1 : sd;
      m_s2 = m_s1;
      m_poly = (pl == 0) ? DEF_POLY : pl;
      m_mode = md;
      m_lk1 = 1'b0; m_lk2 = 1'b0; m_vld = 1'b1;
    end else if (hs) begin
      n = ref_adv(m_s1, m_poly, m_mode, 1);
      if (n == 0) begin n = 1; m_lk1 = 1'b1; end
      m_s1 = n;
      n = ref_adv(m_s2, m_poly, m_mode, 2);
      if (n == 0) begin n = 1; m_lk2 = 1'b1; end
      m_s2 = n;
      m_vld = en;
    end else if (!m_vld && en) begin
      m_vld = 1'b1;
    end
    #1;
    check_all();
  endtask

  task automatic load(input logic [W-1:0] s, input logic [W-1:0] p, input logic md);
    seed = s; poly = p; mode = md; seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] held;
    rst = 1'b1; enable = 1'b0; seed_valid = 1'b0; seed = '0; poly = '0;
    mode = 1'b0; out_ready = 1'b0;
    model_reset();
    #12;
    check_all();
    chk("reset_rand", 64'(rand1), 64'h1);
    rst = 1'b0;

    // Fibonacci, default poly
    out_ready = 1'b1; enable = 1'b1;
    load(16'hACE1, 16'h0000, 1'b0);
    chk("fib_w0", 64'(rand1), 64'hACE1);
    chk("fib2_w0", 64'(rand2), 64'hACE1);
    tick();
    chk("fib_w1", 64'(rand1), 64'h5670);
    chk("fib2_w1", 64'(rand2), 64'hAB38);
    tick();
    chk("fib_w2", 64'(rand1), 64'hAB38);

    // Galois, load coincident with a handshake
    load(16'h0001, 16'hB400, 1'b1);
    chk("gal_w0", 64'(rand1), 64'h0001);
    tick();
    chk("gal_w1", 64'(rand1), 64'hB400);
    tick();
    chk("gal_w2", 64'(rand1), 64'h5A00);
    load(16'h0000, 16'hB400, 1'b1);
    chk("zero_seed", 64'(rand1), 64'h0001);

    // Lock-up recovery and sticky flag
    load(16'h0001, 16'h0002, 1'b0);
    chk("lk_before", 64'(lockup1), 64'h0);
    tick();
    chk("lk_word", 64'(rand1), 64'h0001);
    chk("lk_set", 64'(lockup1), 64'h1);
    repeat (3) tick();
    chk("lk_sticky", 64'(lockup1), 64'h1);
    load(16'hACE1, 16'h0000, 1'b0);
    chk("lk_clear", 64'(lockup1), 64'h0);

    // Backpressure with pause request
    enable = 1'b0; out_ready = 1'b0;
    held = rand1;
    repeat (5) tick();
    chk("bp_hold", 64'(rand1), 64'(held));
    chk("bp_valid", 64'(out_valid1), 64'h1);
    chk("bp_seed_ready", 64'(seed_ready1), 64'h0);
    out_ready = 1'b1;
    tick();
    chk("bp_idle", 64'(out_valid1), 64'h0);
    out_ready = 1'b0;
    load(16'h1234, 16'h0000, 1'b0);
    chk("idle_load_valid", 64'(out_valid1), 64'h1);
    chk("idle_load_word", 64'(rand1), 64'h1234);
    out_ready = 1'b1;
    tick();
    chk("idle_load_back", 64'(out_valid1), 64'h0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      enable     = ($urandom % 4) != 0;
      out_ready  = ($urandom % 3) != 0;
      seed_valid = ($urandom % 10) == 0;
      seed       = ($urandom % 8 == 0) ? '0 : W'($urandom);
      poly       = ($urandom % 4 == 0) ? '0 : W'($urandom);
      mode       = $urandom % 2;
      tick();
    end
    seed_valid = 1'b0;

    // Async reset mid-stream with lockup set
    enable = 1'b1; out_ready = 1'b1;
    load(16'h0001, 16'h0002, 1'b0);
    tick();
    chk("pre_rst_lock", 64'(lockup1), 64'h1);
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_valid", 64'(out_valid1), 64'h0);
    chk("rst_rand", 64'(rand1), 64'h0001);
    chk("rst_lock", 64'(lockup1), 64'h0);
    check_all();
    #1 rst = 1'b0;
    tick();
    chk("resume_w0", 64'(rand1), 64'h0001);
    tick();
    chk("resume_w1", 64'(rand1), 64'h8000);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prg_lfsr_stream.md
Name: prg_lfsr_stream

Overview:
Parametrised successor to the 16-bit Fibonacci pseudo-random generator. It adds:
- configurable width
- runtime-selectable Fibonacci/Galois mode
- a runtime tap polynomial
- multiple shift steps per output word
- zero-state lock-up recovery with a sticky flag

Words are delivered on a valid/ready stream, and seeds are loaded through their own valid/ready handshake. It sits between a test/stimulus controller and any consumer of random words.

Parameters:
WIDTH, 16, LFSR and output word width (4..64)
DEFAULT_POLY, 16'hE801, tap mask used after reset and whenever a zero poly is loaded; WIDTH bits
STEPS, 1, LFSR shifts applied per accepted word (1..WIDTH), unrolled combinationally

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
enable  input  1  run request; low requests pause
seed_valid  input  1  seed/config load request
seed_ready  output  1  load accepted when seed_valid && seed_ready
seed  input  WIDTH  seed value; 0 replaced by 1
poly  input  WIDTH  tap mask latched with seed; 0 replaced by DEFAULT_POLY
mode  input  1  latched with seed; 0 = Fibonacci, 1 = Galois
out_valid  output  1  rand_data valid
out_ready  input  1  consumer accepts word
rand_data  output  WIDTH  current LFSR state
lockup  output  1  sticky; set when a zero state was forced to 1

Behaviour:
- Reset (async, rst=1). All outputs are registered except seed_ready.
  - Internal state: lfsr=1, poly_r=DEFAULT_POLY, mode_r=0, FSM=IDLE.
  - Outputs: out_valid=0, rand_data=1, lockup=0.
- Single step functions:
  - Fibonacci: s' = {^(s & poly_r), s[WIDTH-1:1]}.
  - Galois: s' = (s >> 1) ^ (s[0] ? poly_r : 0).
- adv(s) = step applied STEPS times in series. If adv(s)==0, load 1 instead and set lockup.
- FSM states:
  - IDLE: out_valid=0.
    - Goes to RUN on the next edge if enable=1 or a seed load occurs.
  - RUN: out_valid=1. rand_data holds stable while out_valid && !out_ready.
    - On handshake (out_valid && out_ready): lfsr <= adv(lfsr), visible the next cycle (1-cycle latency).
    - On handshake with enable=0: lfsr advances and the FSM goes to IDLE.
    - With enable=0 and no handshake: stay in RUN, hold data. Valid is never withdrawn before acceptance.
- seed_ready = (FSM==IDLE) || out_ready. This is combinational, so a load never changes data under a pending word.
- Seed load (seed_valid && seed_ready):
  - lfsr <= (seed==0 ? 1 : seed)
  - poly_r <= (poly==0 ? DEFAULT_POLY : poly)
  - mode_r <= mode
  - lockup <= 0
  - FSM <= RUN
- Simultaneous load and output handshake: the presented word counts as consumed, the load wins over the advance, and the next word is the seed.
- Load in IDLE with enable=0: the FSM still enters RUN and presents the seed. After that word is accepted it returns to IDLE.
- lockup is cleared only by rst or a seed load.
- Reset asserted mid-operation: everything returns to reset values immediately, and any pending word is dropped.
- Width rule: all arithmetic is WIDTH bits. The parity reduction is over WIDTH bits; no carries.

Decomposition:
- Shared package prg_pkg holds:
  - the mode encoding (MODE_FIB=0, MODE_GAL=1)
  - the FSM state enum (IDLE, RUN)
  - DEFAULT_POLY constants per common width (16'hE801, 32'h8020_0003, 8'hB8)
- One natural sub-module: prg_lfsr_step.
  - Purely combinational single step, with inputs s, poly, mode.
  - Instantiated STEPS times in a generate chain; the top module holds the FSM, registers and handshakes.

Test Plan:
1. Fibonacci, WIDTH=16, STEPS=1.
   - Stimulus: load seed 16'hACE1 with poly=0, mode=0; out_ready=1, enable=1.
   - Required: words 16'hACE1, then 16'h5670, then 16'hAB38.
2. STEPS=2, same load.
   - Required: words 16'hACE1, then 16'hAB38.
3. Galois.
   - Stimulus: seed 16'h0001, poly 16'hB400, mode=1.
   - Required: words 16'h0001, 16'hB400, 16'h5A00.
   - Also load seed=0: the first word is 16'h0001.
4. Lock-up.
   - Stimulus: Fibonacci, poly 16'h0002, seed 16'h0001, then accept one word.
   - Required: the next word is 16'h0001 and lockup=1. It stays 1 until the next seed load clears it.
5. Backpressure and pause.
   - Stimulus: out_ready=0 for 5 cycles with enable dropped to 0.
   - Required: out_valid stays 1 and rand_data stays stable. seed_ready=0. After one accept, out_valid=0 (IDLE).
6. Async reset mid-stream (rst pulse between edges).
   - Required: immediately out_valid=0, rand_data=16'h0001, lockup=0. After release with enable=1, the Fibonacci sequence resumes from 1 using DEFAULT_POLY.
